// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX datapath among N_REQ byte producers.
// Optional frame timeout compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int          N_REQ    = 4,
  parameter logic [19:0] BAUD_MIN = 20'd15,
  parameter logic [23:0] TIMEOUT  = 24'd2_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [19:0]        baud,
  input  logic [9:0]         tx_bit_cnt,
  output logic               tx_sel,
  output logic               tx_set,
  output logic [7:0]         tx_din,
  output logic [2:0]         gnt_id,
  output logic               busy,
  output logic               done,
  output logic               err
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("uart_tx_arb: N_REQ must be in 2..8");
  end
  if (TIMEOUT == 24'd0) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        abort_q, abort_nxt;
  logic [2:0]  ptr, ptr_nxt;
  logic        baud_ok;
  logic [7:0]  valid8;
  logic [63:0] data8;
  logic        win_found;
  logic [2:0]  win_idx;
  logic        accept;
  logic        timeout_hit;

  assign baud_ok = (baud >= BAUD_MIN);
  // Zero-padded views so 3-bit indices always address a full 8-entry range.
  assign valid8  = 8'(req_valid);
  assign data8   = 64'(req_data);

  always_comb begin
    logic [3:0] pos;
    win_found = 1'b0;
    win_idx   = 3'd0;
    pos       = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
      if (!win_found && valid8[pos[2:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[2:0];
      end
    end
  end

  assign accept  = (state == IDLE) && baud_ok && win_found;
  assign ptr_nxt = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (win_idx == 3'(i));
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [23:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= 24'd0;
    end else if (accept) begin
      timer <= 24'd0;
    end else if (state == SEND && timer != 24'hFF_FFFF) begin
      timer <= timer + 24'd1;
    end
  end

  assign timeout_hit = (timer == TIMEOUT - 24'd1);
`else
  assign timeout_hit = 1'b0;
`endif

  // Completion wins over both abort causes when they coincide.
  always_comb begin
    state_nxt = state;
    abort_nxt = abort_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
          abort_nxt = 1'b0;
        end
      end
      SEND: begin
        if (tx_bit_cnt == 10'd10) begin
          state_nxt = DRAIN;
          abort_nxt = 1'b0;
        end else if (!baud_ok || timeout_hit) begin
          state_nxt = DRAIN;
          abort_nxt = 1'b1;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      abort_q <= 1'b0;
      ptr     <= 3'd0;
      tx_din  <= 8'd0;
      gnt_id  <= 3'd0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort_nxt;
      if (accept) begin
        ptr    <= ptr_nxt;
        tx_din <= data8[{win_idx, 3'b000} +: 8];
        gnt_id <= win_idx;
      end
    end
  end

  // DRAIN keeps select high with set low so the TX core clears its counter.
  assign tx_sel = (state != IDLE);
  assign tx_set = (state == SEND);
  assign busy   = (state != IDLE);
  assign done   = (state == DRAIN) && !abort_q;
  assign err    = (state == DRAIN) && abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed, table-driven bench for uart_tx_arb (N_REQ=4, TIMEOUT=50).
module tb_uart_tx_arb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [31:0]  req_data;
  logic [N-1:0] req_ready;
  logic [19:0]  baud;
  logic [9:0]   tx_bit_cnt;
  logic         tx_sel, tx_set, busy, done, err;
  logic [7:0]   tx_din;
  logic [2:0]   gnt_id;

  int checks   = 0;
  int failures = 0;

  uart_tx_arb #(.N_REQ(N), .BAUD_MIN(20'd15), .TIMEOUT(24'd50)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .baud(baud), .tx_bit_cnt(tx_bit_cnt),
    .tx_sel(tx_sel), .tx_set(tx_set), .tx_din(tx_din), .gnt_id(gnt_id),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Packed output view: {ready, sel, set, din, gnt, busy, done, err}
  typedef struct {
    logic         rst;
    logic [N-1:0] valid;
    logic [19:0]  baud;
    logic [9:0]   cnt;
    logic [19:0]  exp;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] bytes [4];

  function automatic logic [19:0] pack(logic [3:0] rdy, logic sel, logic set, logic [7:0] din,
                                       logic [2:0] gnt, logic bsy, logic dn, logic er);
    return {rdy, sel, set, din, gnt, bsy, dn, er};
  endfunction

  function automatic void add(logic r, logic [3:0] v, logic [19:0] b, logic [9:0] c,
                              logic [3:0] rdy, logic sel, logic set, logic [7:0] din,
                              logic [2:0] gnt, logic bsy, logic dn, logic er);
    vec_t e;
    e.rst = r; e.valid = v; e.baud = b; e.cnt = c;
    e.exp = pack(rdy, sel, set, din, gnt, bsy, dn, er);
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [19:0] exp);
    logic [19:0] act;
    act = {req_ready, tx_sel, tx_set, tx_din, gnt_id, busy, done, err};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got rdy=%b sel=%b set=%b din=%h gnt=%0d busy=%b done=%b err=%b, want %h (packed got %h)",
               name, act[19:16], act[15], act[14], act[13:6], act[5:3], act[2], act[1], act[0], exp, act);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5];
    logic [7:0] prev_din;
    logic [2:0] prev_gnt;

    bytes[0] = 8'hA5; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    // Single frame from requester 0
    add(0, 4'b0001, 20'd16, 10'd0, 4'b0001, 0, 0, 8'h00, 3'd0, 0, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 1, 1, 8'hA5, 3'd0, 1, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd5, 4'b0000, 1, 1, 8'hA5, 3'd0, 1, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd10, 4'b0000, 1, 1, 8'hA5, 3'd0, 1, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 1, 0, 8'hA5, 3'd0, 1, 1, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 0, 0, 8'hA5, 3'd0, 0, 0, 0);
    add(1, 4'b0000, 20'd16, 10'd0, 4'b0000, 0, 0, 8'hA5, 3'd0, 0, 0, 0);
    // All requesting: back-to-back frames, accept at F+2 each time
    prev_din = 8'h00; prev_gnt = 3'd0;
    for (int f = 0; f < 5; f++) begin
      add(0, 4'b1111, 20'd16, 10'd0, 4'(1 << order[f]), 0, 0, prev_din, prev_gnt, 0, 0, 0);
      add(0, 4'b1111, 20'd16, 10'd10, 4'b0000, 1, 1, bytes[order[f]], 3'(order[f]), 1, 0, 0);
      add(0, 4'b1111, 20'd16, 10'd0, 4'b0000, 1, 0, bytes[order[f]], 3'(order[f]), 1, 1, 0);
      prev_din = bytes[order[f]]; prev_gnt = 3'(order[f]);
    end
    // Baud below minimum blocks the grant; at the minimum it proceeds
    add(0, 4'b0010, 20'd14, 10'd0, 4'b0000, 0, 0, 8'hA5, 3'd0, 0, 0, 0);
    add(0, 4'b0010, 20'd14, 10'd0, 4'b0000, 0, 0, 8'hA5, 3'd0, 0, 0, 0);
    add(0, 4'b0010, 20'd15, 10'd0, 4'b0010, 0, 0, 8'hA5, 3'd0, 0, 0, 0);
    add(0, 4'b0000, 20'd15, 10'd4, 4'b0000, 1, 1, 8'h22, 3'd1, 1, 0, 0);
    // Baud lost mid-frame aborts
    add(0, 4'b0000, 20'd0, 10'd4, 4'b0000, 1, 1, 8'h22, 3'd1, 1, 0, 0);
    add(0, 4'b0000, 20'd0, 10'd4, 4'b0000, 1, 0, 8'h22, 3'd1, 1, 0, 1);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 0, 0, 8'h22, 3'd1, 0, 0, 0);
    // Completion beats a simultaneous baud abort
    add(0, 4'b0100, 20'd16, 10'd0, 4'b0100, 0, 0, 8'h22, 3'd1, 0, 0, 0);
    add(0, 4'b0000, 20'd0, 10'd10, 4'b0000, 1, 1, 8'h33, 3'd2, 1, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 1, 0, 8'h33, 3'd2, 1, 1, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 0, 0, 8'h33, 3'd2, 0, 0, 0);
    // Reset during SEND; pointer restarts at 0
    add(0, 4'b0100, 20'd16, 10'd0, 4'b0100, 0, 0, 8'h33, 3'd2, 0, 0, 0);
    add(1, 4'b0000, 20'd16, 10'd3, 4'b0000, 1, 1, 8'h33, 3'd2, 1, 0, 0);
    add(0, 4'b1010, 20'd16, 10'd3, 4'b0010, 0, 0, 8'h00, 3'd0, 0, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd10, 4'b0000, 1, 1, 8'h22, 3'd1, 1, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 1, 0, 8'h22, 3'd1, 1, 1, 0);
    add(0, 4'b1000, 20'd16, 10'd0, 4'b1000, 0, 0, 8'h22, 3'd1, 0, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd10, 4'b0000, 1, 1, 8'h44, 3'd3, 1, 0, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 1, 0, 8'h44, 3'd3, 1, 1, 0);
    add(0, 4'b0000, 20'd16, 10'd0, 4'b0000, 0, 0, 8'h44, 3'd3, 0, 0, 0);

    rst = 1'b1; req_valid = '0; baud = 20'd0; tx_bit_cnt = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack(4'b0000, 0, 0, 8'h00, 3'd0, 0, 0, 0));
    baud = 20'd16; req_valid = 4'b0001;
    #1;
    check("reset_ready_comb", pack(4'b0001, 0, 0, 8'h00, 3'd0, 0, 0, 0));
    req_valid = '0;
    next_cycle();

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req_valid = vecs[i].valid;
      baud = vecs[i].baud; tx_bit_cnt = vecs[i].cnt;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
      next_cycle();
    end

    // Frame whose bit counter never reaches 10
    rst = 1'b0; baud = 20'd16; tx_bit_cnt = 10'd3; req_valid = 4'b0001;
    #1;
    check("to_accept", pack(4'b0001, 0, 0, 8'h44, 3'd3, 0, 0, 0));
    next_cycle();
    req_valid = '0;
    for (int k = 1; k <= 51; k++) begin
      #1;
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (k == 51) check("to_abort", pack(4'b0000, 1, 0, 8'hA5, 3'd0, 1, 0, 1));
      else check($sformatf("to_send%0d", k), pack(4'b0000, 1, 1, 8'hA5, 3'd0, 1, 0, 0));
`else
      check($sformatf("to_hold%0d", k), pack(4'b0000, 1, 1, 8'hA5, 3'd0, 1, 0, 0));
`endif
      next_cycle();
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    #1;
    check("to_idle", pack(4'b0000, 0, 0, 8'hA5, 3'd0, 0, 0, 0));
`else
    tx_bit_cnt = 10'd10;
    next_cycle();
    tx_bit_cnt = 10'd0;
    #1;
    check("hold_done", pack(4'b0000, 1, 0, 8'hA5, 3'd0, 1, 1, 0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin scheduler that shares one UART transmit datapath between up to eight byte producers. Each producer offers a byte over a valid/ready handshake. The block grants one producer and latches its byte. It drives the transmitter's select/set controls, watches the transmitter's bit counter until the frame completes, then releases the channel. It sits between the bus-side byte sources and the UART TX core, in the system clock domain.

## Interface
- `N_REQ`, 4: number of requesters, legal 2..8.
- `BAUD_MIN`, 20'd15: smallest baud divisor treated as valid; matches the TX core's validity rule.
- `TIMEOUT`, 24'd2_000_000: `clk` cycles allowed per frame before abort (only with `UART_TX_ARB_TIMEOUT_EN`).
- `clk` in 1: system clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester byte offered.
- `req_data` in 8*N_REQ: flattened bytes; requester i uses `[8i+7:8i]`.
- `req_ready` out N_REQ: one-hot accept, combinational.
- `baud` in 20: current baud divisor.
- `tx_bit_cnt` in 10: registered bit counter from the TX core; 10 = frame finished.
- `tx_sel` out 1: TX core select.
- `tx_set` out 1: TX core start/hold.
- `tx_din` out 8: byte to transmit.
- `gnt_id` out 3: index of the current or last granted requester.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse when a frame completes normally.
- `err` out 1: one-cycle pulse on an aborted frame.

## Operation
- States: IDLE, SEND, DRAIN. Encoding is free; the state is registered.
- **IDLE**
  - `tx_sel`=0, `tx_set`=0.
  - `baud_ok` = (`baud` >= `BAUD_MIN`).
  - If `baud_ok` and any `req_valid` is high, `req_ready` is one-hot for the winner and is 0 otherwise.
  - Winner: first valid index found searching upward from `ptr`, wrapping modulo N_REQ.
  - On accept: latch `req_data` of the winner into `tx_din`, set `gnt_id` to the winner, set `ptr` to (winner+1) mod N_REQ, then go to SEND.
- **SEND**
  - `tx_sel`=1, `tx_set`=1, `req_ready`=0.
  - If `tx_bit_cnt`==10, go to DRAIN with a normal completion.
  - Else if `baud_ok`=0, go to DRAIN with an abort.
  - Else if the timeout expires (macro enabled), go to DRAIN with an abort.
  - Completion takes precedence over both abort causes when they occur in the same cycle.
- **DRAIN**
  - `tx_sel`=1, `tx_set`=0, so the TX core clears its counter.
  - `done`=1 for a normal completion; `err`=1 for an abort.
  - Always returns to IDLE on the next cycle.
- `tx_din` and `gnt_id` hold their values until the next accept.
- Reset values: state=IDLE, `ptr`=0, `tx_din`=0, `gnt_id`=0, `tx_sel`=0, `tx_set`=0, `busy`=0, `done`=0, `err`=0, timer=0. `req_ready` is then 0 unless `baud_ok` and some `req_valid` is high.
- Reset mid-frame: the next cycle is IDLE with `tx_set`=0. No `done` or `err` pulse is produced.
- `req_valid` dropping while not granted has no effect; there is no requirement on producers to hold `req_valid`.

## Timing
- Accept on edge T (`req_valid`&`req_ready` sampled high).
  - SEND from cycle T+1: `tx_set`=1 and `tx_din` are valid at T+1.
  - `busy` is 1 from T+1.
- First cycle in SEND with `tx_bit_cnt`==10 is cycle F. DRAIN is at F+1, where `done` pulses.
- IDLE at F+2; the earliest next accept is at F+2.
- Maximum throughput: one byte per frame + 2 `clk` cycles.
- Timer: cleared on accept, incremented each SEND cycle, saturates. The abort condition is timer == `TIMEOUT`-1.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A 24-bit frame timer is compiled in.
  - A SEND lasting `TIMEOUT` cycles without `tx_bit_cnt`==10 goes to DRAIN and pulses `err`.
- Not defined:
  - No timer logic.
  - SEND waits indefinitely; only an invalid baud causes an abort.

## Test plan
- Reset, then `baud`=20'd16 and `req_valid`=4'b0001 with byte 8'hA5 -> `req_ready`=4'b0001 in the same cycle. `tx_din`=8'hA5, `tx_set`=1 next cycle, `gnt_id`=0. The model drives `tx_bit_cnt` to 10, then `done` pulses one cycle later.
- `req_valid`=4'b1111 held through 5 frames -> grant order 0,1,2,3,0. `req_ready` is never high while `busy`=1.
- `baud`=20'd14 with `req_valid`=4'b0010 -> `req_ready`=0 and state stays IDLE. After `baud`=20'd15, requester 1 is accepted in that cycle.
- `baud` drops to 20'd0 mid-SEND with `tx_bit_cnt`=4 -> DRAIN, `err`=1 and `done`=0 for one cycle, then IDLE.
- Timeout build with `TIMEOUT`=24'd50 and `tx_bit_cnt` stuck at 3 -> `err` pulses at accept+51, `tx_set`=0 at that cycle.
- `rst`=1 during SEND -> next cycle `tx_set`=0, `busy`=0, `ptr`=0, no `done`/`err` pulse. After reset, `req_valid`=4'b1000 is granted with `gnt_id`=3.
